// File: rtl/imm_pkg.sv
// Shared definitions for the RV32I immediate generator: format codes,
// format-code width and the XLEN legality check.
package imm_pkg;

    localparam int IMM_FMT_W = 3;

    localparam logic [IMM_FMT_W-1:0] IMM_FMT_I = 3'd0;
    localparam logic [IMM_FMT_W-1:0] IMM_FMT_S = 3'd1;
    localparam logic [IMM_FMT_W-1:0] IMM_FMT_B = 3'd2;
    localparam logic [IMM_FMT_W-1:0] IMM_FMT_U = 3'd3;
    localparam logic [IMM_FMT_W-1:0] IMM_FMT_J = 3'd4;
    localparam logic [IMM_FMT_W-1:0] IMM_FMT_Z = 3'd5;

    function automatic bit imm_xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate extraction and sign extension for one instruction.
// Format Z (CSR zimm) is legal only when IMM_GEN_ZIMM_EN is defined.
module imm_ext_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMM_FMT_W-1:0] fmt,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    logic [31:0] imm32_s;
    logic        unused_opcode_s;

    // Opcode bits never carry immediate data.
    assign unused_opcode_s = ^instr[6:0];

    // Assemble the 32-bit immediate for the selected format; illegal codes yield zero.
    always_comb begin
        imm32_s = 32'h0000_0000;
        err     = 1'b0;
        case (fmt)
            IMM_FMT_I: imm32_s = {{20{instr[31]}}, instr[31:20]};
            IMM_FMT_S: imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_FMT_B: imm32_s = {{19{instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0};
            IMM_FMT_U: imm32_s = {instr[31:12], 12'h000};
            IMM_FMT_J: imm32_s = {{11{instr[31]}}, instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
            IMM_FMT_Z: imm32_s = {27'h000_0000, instr[19:15]};
`endif
            default: begin
                imm32_s = 32'h0000_0000;
                err     = 1'b1;
            end
        endcase
    end

    // Bit 31 of every 32-bit form is already the sign (zero for zimm), so a
    // signed widen covers the XLEN=64 case uniformly.
    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/imm_gen.sv
// Two-stage valid/ready immediate generator (S1: raw instruction, S2: result).
// Optional CSR zimm support is enabled with IMM_GEN_ZIMM_EN.
module imm_gen
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [IMM_FMT_W-1:0] in_fmt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [IMM_FMT_W-1:0] out_fmt,
    output logic                 out_err
);

    if (!imm_xlen_ok(XLEN)) begin : g_xlen_chk
        $error("imm_gen: XLEN must be 32 or 64");
    end

    logic                 s1_valid_r;
    logic [31:0]          s1_instr_r;
    logic [IMM_FMT_W-1:0] s1_fmt_r;

    logic                 s2_load_s;
    logic                 s1_load_s;
    logic [XLEN-1:0]      ext_imm_s;
    logic                 ext_err_s;

    // S2 can take new data when empty or being drained; S1 likewise when it drains into S2.
    assign s2_load_s = !out_valid || out_ready;
    assign s1_load_s = !s1_valid_r || s2_load_s;
    assign in_ready  = !flush && s1_load_s;

    imm_ext_comb #(
        .XLEN (XLEN)
    ) u_ext (
        .instr (s1_instr_r),
        .fmt   (s1_fmt_r),
        .imm   (ext_imm_s),
        .err   (ext_err_s)
    );

    // Pipeline registers and valid tracking; flush kills both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_instr_r <= 32'h0000_0000;
            s1_fmt_r   <= 3'd0;
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_fmt    <= 3'd0;
            out_err    <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (s2_load_s) begin
                out_valid <= s1_valid_r;
                if (s1_valid_r) begin
                    out_imm <= ext_imm_s;
                    out_fmt <= s1_fmt_r;
                    out_err <= ext_err_s;
                end
            end
            if (s1_load_s) begin
                s1_valid_r <= in_valid;
                if (in_valid) begin
                    s1_instr_r <= in_instr;
                    s1_fmt_r   <= in_fmt;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Directed bench for imm_gen: vector table on XLEN=32 and XLEN=64 instances,
// plus backpressure, flush and asynchronous-reset sequences.
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_err;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        out_err64;

    int total;
    int bad;

    imm_gen #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_fmt    (in_fmt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt),
        .out_err   (out_err)
    );

    imm_gen #(.XLEN(64)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .in_instr  (in_instr),
        .in_fmt    (in_fmt),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .out_imm   (out_imm64),
        .out_fmt   (out_fmt64),
        .out_err   (out_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] exp;
        logic [63:0] exp64;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_q[3];
        int          idx;

        total = 0;
        bad   = 0;

        vecs[0]  = '{32'hFFF0_0093, 3'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1]  = '{32'h1230_0093, 3'd0, 32'h0000_0123, 64'h0000_0000_0000_0123, 1'b0};
        vecs[2]  = '{32'hFE11_2E23, 3'd1, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[3]  = '{32'h0011_2423, 3'd1, 32'h0000_0008, 64'h0000_0000_0000_0008, 1'b0};
        vecs[4]  = '{32'hFE00_0EE3, 3'd2, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[5]  = '{32'h1234_5037, 3'd3, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0};
        vecs[6]  = '{32'h8000_0037, 3'd3, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[7]  = '{32'h0080_006F, 3'd4, 32'h0000_0008, 64'h0000_0000_0000_0008, 1'b0};
        vecs[8]  = '{32'hFFDF_F06F, 3'd4, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b1};
        vecs[10] = '{32'hFFF0_0093, 3'd6, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b1};
`ifdef IMM_GEN_ZIMM_EN
        vecs[11] = '{32'h000F_8073, 3'd5, 32'h0000_001F, 64'h0000_0000_0000_001F, 1'b0};
`else
        vecs[11] = '{32'h000F_8073, 3'd5, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b1};
`endif

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_fmt    = 3'd0;
        out_ready = 1'b0;

        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_imm", {32'd0, out_imm}, 64'd0);
        chk("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: one transaction each, output checked two edges after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_fmt   = vecs[i].fmt;
            chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_early_valid", i), {63'd0, out_valid}, 64'd0);
            step();
            chk($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("v%0d_imm", i), {32'd0, out_imm}, {32'd0, vecs[i].exp});
            chk($sformatf("v%0d_fmt", i), {61'd0, out_fmt}, {61'd0, vecs[i].fmt});
            chk($sformatf("v%0d_err", i), {63'd0, out_err}, {63'd0, vecs[i].err});
            chk($sformatf("v%0d_imm64", i), out_imm64, vecs[i].exp64);
            chk($sformatf("v%0d_err64", i), {63'd0, out_err64}, {63'd0, vecs[i].err});
        end
        step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: two accepts fill the pipe, third input is held upstream.
        exp_q[0] = 32'h0000_0001;
        exp_q[1] = 32'h0000_0002;
        exp_q[2] = 32'h0000_0003;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd0;
        in_instr  = 32'h0010_0093;
        chk("bp_ready_a", {63'd0, in_ready}, 64'd1);
        step();
        in_instr = 32'h0020_0093;
        chk("bp_ready_b", {63'd0, in_ready}, 64'd1);
        step();
        in_instr = 32'h0030_0093;
        chk("bp_ready_c_blocked", {63'd0, in_ready}, 64'd0);
        step();
        step();
        chk("bp_still_blocked", {63'd0, in_ready}, 64'd0);
        chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_imm", {32'd0, out_imm}, {32'd0, exp_q[0]});
        step();
        chk("bp_hold_imm2", {32'd0, out_imm}, {32'd0, exp_q[0]});
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", {63'd0, in_ready}, 64'd1);
        idx = 0;
        for (int n = 0; n < 8 && idx < 3; n++) begin
            if (out_valid) begin
                chk($sformatf("bp_out%0d", idx), {32'd0, out_imm}, {32'd0, exp_q[idx]});
                idx++;
            end
            step();
            in_valid = 1'b0;
        end
        chk("bp_count", 64'(idx), 64'd3);
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Flush with both stages full: flush-cycle input must be dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0040_0093;
        step();
        in_instr = 32'h0050_0093;
        step();
        chk("fl_full_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_instr  = 32'h0070_0093;
        #1;
        chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        flush = 1'b0;
        chk("fl_valid_cleared", {63'd0, out_valid}, 64'd0);
        in_instr = 32'h0060_0093;
        #1;
        chk("fl_ready_after", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("fl_no_ghost", {63'd0, out_valid}, 64'd0);
        step();
        chk("fl_new_valid", {63'd0, out_valid}, 64'd1);
        chk("fl_new_imm", {32'd0, out_imm}, 64'd6);
        step();
        chk("fl_after_empty", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset in mid-cycle empties the pipe without a clock edge.
        in_valid = 1'b1;
        in_instr = 32'h0080_0093;
        step();
        in_valid = 1'b0;
        step();
        chk("ar_valid_before", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_imm", {32'd0, out_imm}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("ar_stays_empty", {63'd0, out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen.md
# imm_gen

Pipelined, parametrised immediate generator for the decode stage of the RISC-V core. It extracts and sign-extends the immediate of every RV32I instruction format from the raw instruction word to XLEN bits. A two-stage valid/ready pipeline lets it sit between the fetch/decode boundary and the register-read stage without a combinational critical path.

## Interface
- XLEN, default 32: output immediate width. Legal values are 32 and 64.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block accepts `in_instr`/`in_fmt` this cycle.
- in_instr  in  32  raw instruction word.
- in_fmt  in  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm); 6 and 7 are illegal.
- out_valid  out  1  `out_imm` is valid.
- out_ready  in  1  downstream consumes the output.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code carried along with the immediate.
- out_err  out  1  format was illegal; `out_imm` is 0.

## Operation
- Stage S1 registers `in_instr` and `in_fmt` on each input transfer (`in_valid & in_ready`).
- Stage S2 registers the computed `out_imm`, `out_fmt` and `out_err` when S1 advances.
- Extraction rules, with sext meaning sign-extend from the bit shown to XLEN:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: sext({instr[31:12], 12'h000}). For XLEN=64, bit 31 is replicated.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Z: zero-extend instr[19:15].
- Illegal format: `out_imm`=0 and `out_err`=1. The transaction still flows through the pipeline.
- Advance rules:
  - S2 loads when S2 is empty or `out_ready`=1.
  - S1 loads when S1 is empty or S1 advances.
  - in_ready = !s1_valid | !s2_valid | out_ready.
- `flush`:
  - Clears both stage valids at the next edge.
  - `in_ready` is forced to 0 in the flush cycle, so any input in that cycle is not accepted.
  - Flush dominates all simultaneous events.
- Ordering is strictly FIFO. No transaction is dropped or duplicated except by flush.

## Timing
- Reset values: `out_valid`=0, `out_imm`=0, `out_fmt`=0, `out_err`=0; S1 valid=0. `in_ready`=1 after reset.
- Latency is 2 cycles: an input accepted at edge N gives `out_valid`=1 after edge N+1 and can be consumed at edge N+2.
- Throughput is 1 per cycle with `out_ready` held high.
- With `out_ready`=0 the pipeline holds two entries and `in_ready` drops to 0. Output data is stable while `out_valid & !out_ready`.
- `out_ready` feeds `in_ready` combinationally. No other combinational input-to-output path exists.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Configuration
- `IMM_GEN_ZIMM_EN` defined: format 5 (Z) is legal and zero-extends instr[19:15].
- Not defined: format 5 is treated as illegal (`out_err`=1, `out_imm`=0). The Z extraction logic is not synthesised.

## Structure
- Shared package `imm_pkg` holds:
  - the format-code constants IMM_FMT_I/S/B/U/J/Z;
  - the XLEN legality check;
  - the format width of 3.
- Sub-module `imm_ext_comb` is purely combinational: instr, fmt → imm, err. It is instantiated between S1 and S2. The top level owns the pipeline registers and handshake only.

## Test plan
- I-type: in_instr=0xFFF00093 (addi x1,x0,-1), fmt=0 → `out_imm`=0xFFFFFFFF, `out_err`=0, two cycles after acceptance.
- B-type: in_instr=0xFE000EE3 (beq x0,x0,-4), fmt=2 → `out_imm`=0xFFFFFFFC.
- U-type:
  - XLEN=32, in_instr=0x12345037, fmt=3 → 0x12345000.
  - XLEN=64, in_instr=0x80000037 → 0xFFFFFFFF80000000.
- Backpressure: three back-to-back inputs with `out_ready`=0 for 4 cycles → `in_ready`=0 after two accepts. The third input is held by upstream. Outputs then appear in order once `out_ready`=1, with no loss.
- Flush: both stages full, `flush`=1 together with `in_valid`=1 → next cycle `out_valid`=0, the input is not accepted, and a new input is accepted in the following cycle.
- Illegal formats:
  - fmt=7 → `out_err`=1, `out_imm`=0.
  - fmt=5, in_instr[19:15]=0x1F: with `IMM_GEN_ZIMM_EN` → `out_imm`=0x1F, `out_err`=0; without it → `out_err`=1.
